// File: rtl/mul_pkg.sv
// Shared constants for the pipelined multiplier.
package mul_pkg;
   localparam int MUL_LATENCY       = 3;
   localparam int MUL_GROUPS        = 4;
   localparam int MUL_W_DEFAULT     = 32;
   localparam int MUL_TAG_W_DEFAULT = 4;
endpackage

// File: rtl/mul_pp_group.sv
// Sums a contiguous group of shifted partial-product rows into one 2W-bit partial sum.
module mul_pp_group #(
   parameter int W    = 32,
   parameter int ROWS = 8,
   parameter int BASE = 0
) (
   input  logic [W-1:0]    mcand,
   input  logic [ROWS-1:0] mplier,
   output logic [2*W-1:0]  psum
);

   logic [2*W-1:0] mcand_ext;

   assign mcand_ext = {{W{1'b0}}, mcand};

   // Accumulate each row whose multiplier bit is set, shifted to its absolute weight.
   always_comb begin
      psum = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (mplier[i]) begin
            psum = psum + (mcand_ext << (BASE + i));
         end
      end
   end

endmodule

// File: rtl/mul_pipe.sv
// Three-stage signed/unsigned multiplier with valid/ready handshake, tag sideband,
// flush and synchronous reset. A stall freezes every stage as a unit.
module mul_pipe
   import mul_pkg::*;
#(
   parameter int W     = MUL_W_DEFAULT,
   parameter int TAG_W = MUL_TAG_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     op1,
   input  logic [W-1:0]     op2,
   input  logic             op1_signed,
   input  logic             op2_signed,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int ROWS = W / MUL_GROUPS;

   generate
      if ((W % MUL_GROUPS) != 0) begin : g_bad_w
         $error("mul_pipe: W must be divisible by 4");
      end
      if ((W < 8) || (W > 64) || ((W % 2) != 0)) begin : g_bad_range
         $error("mul_pipe: W must be even and within 8..64");
      end
      if (MUL_LATENCY != 3) begin : g_bad_lat
         $error("mul_pipe: pipeline is built for exactly three stages");
      end
   endgenerate

   logic stall;
   logic advance;
   logic take;

   logic           op1_neg;
   logic           op2_neg;
   logic [W-1:0]   mag1_c;
   logic [W-1:0]   mag2_c;

   logic             s1_valid;
   logic [W-1:0]     s1_mag1;
   logic [W-1:0]     s1_mag2;
   logic             s1_neg;
   logic [TAG_W-1:0] s1_tag;

   logic [2*W-1:0]   pp [MUL_GROUPS];

   logic             s2_valid;
   logic [2*W-1:0]   s2_psum [MUL_GROUPS];
   logic             s2_neg;
   logic [TAG_W-1:0] s2_tag;

   logic [2*W-1:0]   sum_c;

   assign stall    = out_valid & ~out_ready;
   assign advance  = ~stall;
   assign in_ready = ~reset & ~flush & ~stall;
   assign take     = in_valid & in_ready;

   // Operand magnitudes; the W-bit negation keeps -2^(W-1) as 2^(W-1) unsigned.
   always_comb begin
      op1_neg = op1_signed & op1[W-1];
      op2_neg = op2_signed & op2[W-1];
      mag1_c  = op1_neg ? (~op1 + 1'b1) : op1;
      mag2_c  = op2_neg ? (~op2 + 1'b1) : op2;
   end

   // Stage valid bits; reset and flush both empty the pipe, bubbles advance like entries.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         s1_valid  <= 1'b0;
         s2_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         s1_valid  <= take;
         s2_valid  <= s1_valid;
         out_valid <= s2_valid;
      end
   end

   // S1 capture: magnitudes, product sign and tag.
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_mag1 <= mag1_c;
         s1_mag2 <= mag2_c;
         s1_neg  <= op1_neg ^ op2_neg;
         s1_tag  <= in_tag;
      end
   end

   genvar g;
   generate
      for (g = 0; g < MUL_GROUPS; g++) begin : g_pp
         mul_pp_group #(
            .W    (W),
            .ROWS (ROWS),
            .BASE (g * ROWS)
         ) u_pp_group (
            .mcand  (s1_mag1),
            .mplier (s1_mag2[g*ROWS +: ROWS]),
            .psum   (pp[g])
         );
      end
   endgenerate

   // S2 capture: one partial sum per row group.
   always_ff @(posedge clk) begin
      if (advance) begin
         for (int i = 0; i < MUL_GROUPS; i++) begin
            s2_psum[i] <= pp[i];
         end
         s2_neg <= s1_neg;
         s2_tag <= s1_tag;
      end
   end

   // Final carry-propagate sum of the group partial sums.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < MUL_GROUPS; i++) begin
         sum_c = sum_c + s2_psum[i];
      end
   end

   // S3: result and tag only change when a live entry lands, so they hold across bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         result  <= '0;
         out_tag <= '0;
      end else if (advance && s2_valid && !flush) begin
         result  <= s2_neg ? (~sum_c + 1'b1) : sum_c;
         out_tag <= s2_tag;
      end
   end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed bench for mul_pipe with hand-computed expected values.
module tb_mul_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] op1;
   logic [31:0] op2;
   logic        op1_signed;
   logic        op2_signed;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic [3:0]  out_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mul_pipe #(.W(32), .TAG_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op1        (op1),
      .op2        (op2),
      .op1_signed (op1_signed),
      .op2_signed (op2_signed),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .out_tag    (out_tag)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic sa, input logic sb, input logic [3:0] t,
                          input logic [63:0] exp);
      int cyc;
      op1 = a; op2 = b; op1_signed = sa; op2_signed = sb; in_tag = t;
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      tick();
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         tick();
         cyc++;
      end
      chk({name, "_latency"}, 64'(cyc), 64'd3);
      chk({name, "_result"}, result, exp);
      chk({name, "_tag"}, {60'd0, out_tag}, {60'd0, t});
      tick();
      chk({name, "_drained"}, {63'd0, out_valid}, 64'd0);
   endtask

   initial begin
      int issued;
      int returned;
      int seen;

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; op1 = '0; op2 = '0;
      op1_signed = 1'b0; op2_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_result", result, 64'd0);
      chk("rst_out_tag", {60'd0, out_tag}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

      run_one("ss_m1_m1",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'd3, 64'h0000_0000_0000_0001);
      run_one("ss_min_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd4, 64'h4000_0000_0000_0000);
      run_one("uu_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 4'd5, 64'hFFFF_FFFE_0000_0001);
      run_one("su_m1_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd6, 64'hFFFF_FFFF_0000_0001);
      run_one("us_max_m1",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'd7, 64'hFFFF_FFFF_0000_0001);
      run_one("ss_m3_5",    32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b1, 4'd8, 64'hFFFF_FFFF_FFFF_FFF1);
      run_one("ss_zero_neg",32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 4'd9, 64'h0000_0000_0000_0000);
      run_one("uu_big",     32'h1234_5678, 32'h0000_1000, 1'b0, 1'b0, 4'hA, 64'h0000_0123_4567_8000);

      // Back-to-back stream of five with the consumer stalled in cycles 4..6.
      issued = 0;
      returned = 0;
      op1_signed = 1'b0; op2_signed = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         out_ready = !(c >= 4 && c <= 6);
         in_valid  = (issued < 5);
         in_tag    = 4'(issued + 1);
         op1       = 32'((issued + 1) * 3);
         op2       = 32'((issued + 1) + 10);
         #1;
         if (c >= 4 && c <= 6) begin
            chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         end
         if (out_valid && out_ready) begin
            returned++;
            chk("order_tag", {60'd0, out_tag}, 64'(returned));
            chk("order_result", result, 64'(returned * 3 * (returned + 10)));
         end
         if (in_valid && in_ready) issued++;
         tick();
      end
      in_valid = 1'b0;
      chk("stream_issued", 64'(issued), 64'd5);
      chk("stream_returned", 64'(returned), 64'd5);

      // Three in flight, then flush coinciding with an offered input.
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         in_tag   = 4'(8 + k);
         op1      = 32'd100 + 32'(k);
         op2      = 32'd2;
         tick();
      end
      out_ready = 1'b0;
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_tag    = 4'd11;
      #1;
      chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) seen++;
         tick();
      end
      chk("flush_none_returned", 64'(seen), 64'd0);

      // Reset pulse with two operations in flight.
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1;
         in_tag   = 4'(12 + k);
         op1      = 32'd50;
         op2      = 32'd3;
         tick();
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      #1;
      chk("rst2_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      reset = 1'b0;
      chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst2_result", result, 64'd0);
      chk("rst2_out_tag", {60'd0, out_tag}, 64'd0);
      run_one("uu_7x9", 32'd7, 32'd9, 1'b0, 1'b0, 4'd2, 64'd63);
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (out_valid) seen++;
         tick();
      end
      chk("rst2_none_returned", 64'(seen), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
